// File: rtl/dus_pkg.sv
// Constants and types shared by the dus core, its stream drain stage and their benches.
package dus_pkg;

    localparam int DUS_ADDR_W     = 10;
    localparam int DUS_DATA_W     = 32;
    localparam int DUS_WORDS      = 1024;
    localparam int DUS_SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dus_drain_state_t;

    // A read may issue only if every word already buffered or returning still fits after this cycle's pop.
    function automatic logic dus_has_credit(input logic [1:0] count, input logic inflight,
                                            input logic pop);
        logic [2:0] w_used;
        w_used = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        return w_used < 3'(DUS_SKID_DEPTH);
    endfunction

endpackage

// File: rtl/dus_stream_drain_if.sv
// Control, result-buffer read port and output stream of the dus drain stage.
interface dus_stream_drain_if
    import dus_pkg::*;
#(
    parameter int DATA_W = DUS_DATA_W,
    parameter int ADDR_W = DUS_ADDR_W
);
    // Stream handshake: a beat transfers on a rising edge where out_valid and out_ready are both 1;
    // once out_valid is high, out_valid/out_data/out_last hold unchanged until that transfer happens.
    logic              ap_start;
    logic              ap_done;
    logic              ap_ready;
    logic              ap_idle;
    logic              dus_ce0;
    logic [ADDR_W-1:0] dus_address0;
    logic [DATA_W-1:0] dus_q0;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        input  ap_start, dus_q0, out_ready,
        output ap_done, ap_ready, ap_idle, dus_ce0, dus_address0, out_valid, out_data, out_last
    );

    modport slave (
        output ap_start, dus_q0, out_ready,
        input  ap_done, ap_ready, ap_idle, dus_ce0, dus_address0, out_valid, out_data, out_last
    );

endinterface

// File: rtl/dus_skid_fifo.sv
// Two-entry register FIFO absorbing the buffer read latency and sink backpressure.
module dus_skid_fifo #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

    // The upstream credit rule keeps a push away from a full FIFO, even with a pop in the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && (r_count == 2'd2)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(pop && (r_count == 2'd0)));

endmodule

// File: rtl/dus_stream_drain.sv
// Drains the dus result buffer as a valid/ready stream under ap_start/ap_done control.
module dus_stream_drain
    import dus_pkg::*;
#(
    parameter int DATA_W    = DUS_DATA_W,
    parameter int ADDR_W    = DUS_ADDR_W,
    parameter int NUM_WORDS = DUS_WORDS
) (
    input  logic             clk,
    input  logic             rst,
    dus_stream_drain_if.master bus,
    output dus_drain_state_t o_dbg_state
);

    localparam logic [ADDR_W:0] LP_END  = (ADDR_W + 1)'(NUM_WORDS);
    localparam logic [ADDR_W:0] LP_LAST = (ADDR_W + 1)'(NUM_WORDS - 1);

    dus_drain_state_t r_state;
    logic             r_ap_done;
    logic             r_ap_idle;
    logic [ADDR_W:0]  r_rd_addr;
    logic             r_inflight;
    logic             r_inflight_last;

    logic [DATA_W:0]  w_head;
    logic [1:0]       w_count;
    logic             w_valid;
    logic             w_pop;
    logic             w_head_last;
    logic             w_issue;

    assign w_valid     = (w_count != 2'd0);
    assign w_pop       = w_valid & bus.out_ready;
    assign w_head_last = w_head[DATA_W];
    assign w_issue     = (r_state == RUN) && (r_rd_addr < LP_END)
                         && dus_has_credit(w_count, r_inflight, w_pop);

    // Each entry carries the word plus its last tag in the top bit.
    dus_skid_fifo #(
        .W(DATA_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_inflight),
        .pop   (w_pop),
        .din   ({r_inflight_last, bus.dus_q0}),
        .dout  (w_head),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_ap_done <= 1'b0;
            r_ap_idle <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.ap_start) begin
                        r_state   <= RUN;
                        r_ap_idle <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_pop && w_head_last) begin
                        r_state   <= DONE;
                        r_ap_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_ap_done <= 1'b0;
                    r_ap_idle <= 1'b1;
                end
                default: begin
                    r_state   <= IDLE;
                    r_ap_done <= 1'b0;
                    r_ap_idle <= 1'b1;
                end
            endcase
        end
    end

    // The address counter only advances in RUN and rewinds to 0 as soon as the run ends.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_addr       <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rd_addr == LP_LAST);
            if (r_state != RUN) begin
                r_rd_addr <= '0;
            end else if (w_issue) begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end
        end
    end

    assign bus.ap_done      = r_ap_done;
    assign bus.ap_ready     = r_ap_done;
    assign bus.ap_idle      = r_ap_idle;
    assign bus.dus_ce0      = w_issue;
    assign bus.dus_address0 = (r_state == RUN) ? r_rd_addr[ADDR_W-1:0] : '0;
    assign bus.out_valid    = w_valid;
    assign bus.out_data     = w_valid ? w_head[DATA_W-1:0] : '0;
    assign bus.out_last     = w_valid & w_head_last;
    assign o_dbg_state      = r_state;

endmodule
